parity_lane_checker: RTL and testbench

- Streaming, pipelined parity checker for received optical-link words.
- Splits each WIDTH-bit word into LANES equal lanes. Each lane carries its own transmitted parity bit.
- Checks every lane against a runtime-selectable even/odd convention and forwards the data with per-lane error flags.
- Keeps a saturating error-beat counter and a sticky error flag for status readout.
- Sits between the deserialiser/framer and the decode logic, using valid/ready handshakes on both sides.

---
 rtl/parity_lane_checker.sv | 96 +++++++++
 tb/tb_parity_lane_checker.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/parity_lane_checker.sv
// Two-stage streaming parity checker: per-lane even/odd check of each word,
// data forwarded with per-lane error flags, plus a saturating error-beat counter and sticky flag.
module parity_lane_checker #(
   parameter int WIDTH     = 28,
   parameter int LANES     = 4,
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 odd_mode_in,
   input  logic [WIDTH-1:0]     data_in,
   input  logic [LANES-1:0]     parity_in,
   input  logic                 valid_in,
   output logic                 ready_out,
   output logic [WIDTH-1:0]     data_out,
   output logic [LANES-1:0]     lane_err_out,
   output logic                 valid_out,
   input  logic                 ready_in,
   output logic [CNT_WIDTH-1:0] err_count_out,
   output logic                 sticky_err_out,
   input  logic                 clear_in
);

   localparam int LW = WIDTH / LANES;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   logic                 s1_valid;
   logic [WIDTH-1:0]     s1_data;
   logic [LANES-1:0]     s1_xor;
   logic                 s1_odd;
   logic [LANES-1:0]     lane_xor;
   logic                 s1_adv;
   logic                 s2_adv;
   logic                 err_beat;

   always_comb begin
      lane_xor = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_xor[k] = (^data_in[k*LW +: LW]) ^ parity_in[k];
      end
   end

   // A stage may load whenever it is empty or its current contents are leaving.
   assign s2_adv    = !valid_out || ready_in;
   assign s1_adv    = !s1_valid || s2_adv;
   assign ready_out = s1_adv;
   assign err_beat  = valid_out && ready_in && (|lane_err_out);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_xor   <= '0;
         s1_odd   <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= valid_in;
         if (valid_in) begin
            s1_data <= data_in;
            s1_xor  <= lane_xor;
            s1_odd  <= odd_mode_in;
         end
      end
   end

   // The mode captured in S1 travels with its word, so mid-stream mode changes only affect later words.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         valid_out    <= 1'b0;
         data_out     <= '0;
         lane_err_out <= '0;
      end else if (s2_adv) begin
         valid_out <= s1_valid;
         if (s1_valid) begin
            data_out     <= s1_data;
            lane_err_out <= s1_xor ^ {LANES{s1_odd}};
         end
      end
   end

   // Clear wins over a simultaneous errored transfer.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         err_count_out  <= '0;
         sticky_err_out <= 1'b0;
      end else if (clear_in) begin
         err_count_out  <= '0;
         sticky_err_out <= 1'b0;
      end else if (err_beat) begin
         sticky_err_out <= 1'b1;
         if (err_count_out != CNT_MAX) begin
            err_count_out <= err_count_out + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_parity_lane_checker.sv
// Directed self-checking bench for parity_lane_checker; a second instance with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_parity_lane_checker;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   logic        odd_mode_in;
   logic [27:0] data_in;
   logic [3:0]  parity_in;
   logic        valid_in;
   logic        ready_in;
   logic        clear_in;
   logic        ready_out, valid_out, sticky_err_out;
   logic [27:0] data_out;
   logic [3:0]  lane_err_out;
   logic [15:0] err_count_out;
   logic        ready2, valid2, sticky2;
   logic [27:0] data2;
   logic [3:0]  lane_err2;
   logic [1:0]  count2;
   int errors = 0;
   int checks = 0;

   parity_lane_checker #(.WIDTH(28), .LANES(4), .CNT_WIDTH(16)) u_dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .odd_mode_in(odd_mode_in),
      .data_in(data_in), .parity_in(parity_in), .valid_in(valid_in),
      .ready_out(ready_out), .data_out(data_out), .lane_err_out(lane_err_out),
      .valid_out(valid_out), .ready_in(ready_in), .err_count_out(err_count_out),
      .sticky_err_out(sticky_err_out), .clear_in(clear_in)
   );

   parity_lane_checker #(.WIDTH(28), .LANES(4), .CNT_WIDTH(2)) u_dut2 (
      .clk_in(clk_in), .rst_n_in(rst_n_in), .odd_mode_in(odd_mode_in),
      .data_in(data_in), .parity_in(parity_in), .valid_in(valid_in),
      .ready_out(ready2), .data_out(data2), .lane_err_out(lane_err2),
      .valid_out(valid2), .ready_in(ready_in), .err_count_out(count2),
      .sticky_err_out(sticky2), .clear_in(clear_in)
   );

   always #5 clk_in = ~clk_in;

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      rst_n_in = 1'b0; odd_mode_in = 1'b0; data_in = '0; parity_in = '0;
      valid_in = 1'b0; ready_in = 1'b1; clear_in = 1'b0;
      #2;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0h expected 0", valid_out); end
      checks++; if (data_out !== 28'h0) begin errors++; $display("[TB] FAIL reset_data: got %0h expected 0", data_out); end
      checks++; if (lane_err_out !== 4'h0) begin errors++; $display("[TB] FAIL reset_lane_err: got %0h expected 0", lane_err_out); end
      checks++; if (err_count_out !== 16'h0) begin errors++; $display("[TB] FAIL reset_count: got %0h expected 0", err_count_out); end
      checks++; if (sticky_err_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_sticky: got %0h expected 0", sticky_err_out); end
      @(negedge clk_in);
      rst_n_in = 1'b1;
      tick();
      checks++; if (ready_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %0h expected 1", ready_out); end
   endtask

   task automatic test_pass();
      data_in = 28'h0000001; parity_in = 4'b0001; odd_mode_in = 1'b0; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL pass_early_valid: got %0h expected 0", valid_out); end
      tick();
      checks++; if (valid_out !== 1'b1) begin errors++; $display("[TB] FAIL pass_valid: got %0h expected 1", valid_out); end
      checks++; if (data_out !== 28'h0000001) begin errors++; $display("[TB] FAIL pass_data: got %0h expected 1", data_out); end
      checks++; if (lane_err_out !== 4'b0000) begin errors++; $display("[TB] FAIL pass_lane_err: got %0h expected 0", lane_err_out); end
      tick();
      checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL pass_single_beat: got %0h expected 0", valid_out); end
      checks++; if (err_count_out !== 16'd0) begin errors++; $display("[TB] FAIL pass_count: got %0h expected 0", err_count_out); end
   endtask

   task automatic test_lane_error();
      data_in = 28'h0004000; parity_in = 4'b0000; odd_mode_in = 1'b0; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      tick();
      checks++; if (lane_err_out !== 4'b0100) begin errors++; $display("[TB] FAIL even_lane_err: got %0h expected 4", lane_err_out); end
      checks++; if (err_count_out !== 16'd0) begin errors++; $display("[TB] FAIL count_before_xfer: got %0h expected 0", err_count_out); end
      tick();
      checks++; if (err_count_out !== 16'd1) begin errors++; $display("[TB] FAIL count_after_xfer: got %0h expected 1", err_count_out); end
      checks++; if (sticky_err_out !== 1'b1) begin errors++; $display("[TB] FAIL sticky_set: got %0h expected 1", sticky_err_out); end
      odd_mode_in = 1'b1; parity_in = 4'b1011; valid_in = 1'b1;
      tick();
      valid_in = 1'b0; odd_mode_in = 1'b0;
      tick();
      checks++; if (lane_err_out !== 4'b0000) begin errors++; $display("[TB] FAIL odd_lane_err: got %0h expected 0", lane_err_out); end
      tick();
      checks++; if (err_count_out !== 16'd1) begin errors++; $display("[TB] FAIL odd_count_held: got %0h expected 1", err_count_out); end
   endtask

   task automatic test_back_to_back();
      ready_in = 1'b0;
      data_in = 28'h0000003; parity_in = 4'b0000; odd_mode_in = 1'b0; valid_in = 1'b1;
      tick();
      data_in = 28'h0000080; parity_in = 4'b0000; odd_mode_in = 1'b1;
      tick();
      data_in = 28'h0200000; parity_in = 4'b1000; odd_mode_in = 1'b0;
      checks++; if (ready_out !== 1'b0) begin errors++; $display("[TB] FAIL bp_ready_low: got %0h expected 0", ready_out); end
      checks++; if (data_out !== 28'h0000003) begin errors++; $display("[TB] FAIL bp_w0_data: got %0h expected 3", data_out); end
      tick();
      checks++; if (valid_out !== 1'b1 || data_out !== 28'h0000003) begin errors++; $display("[TB] FAIL bp_hold: got valid=%0h data=%0h expected valid=1 data=3", valid_out, data_out); end
      checks++; if (lane_err_out !== 4'b0000) begin errors++; $display("[TB] FAIL bp_w0_err: got %0h expected 0", lane_err_out); end
      ready_in = 1'b1;
      #1;
      checks++; if (ready_out !== 1'b1) begin errors++; $display("[TB] FAIL bp_ready_comb: got %0h expected 1", ready_out); end
      tick();
      valid_in = 1'b0;
      checks++; if (data_out !== 28'h0000080) begin errors++; $display("[TB] FAIL bp_w1_data: got %0h expected 80", data_out); end
      checks++; if (lane_err_out !== 4'b1101) begin errors++; $display("[TB] FAIL bp_w1_err: got %0h expected d", lane_err_out); end
      tick();
      checks++; if (valid_out !== 1'b1 || data_out !== 28'h0200000) begin errors++; $display("[TB] FAIL bp_w2_data: got valid=%0h data=%0h expected valid=1 data=200000", valid_out, data_out); end
      checks++; if (lane_err_out !== 4'b0000) begin errors++; $display("[TB] FAIL bp_w2_err: got %0h expected 0", lane_err_out); end
      tick();
      checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL bp_no_dup: got %0h expected 0", valid_out); end
      checks++; if (err_count_out !== 16'd2) begin errors++; $display("[TB] FAIL bp_count: got %0h expected 2", err_count_out); end
   endtask

   task automatic test_clear();
      data_in = 28'h0004000; parity_in = 4'b0000; odd_mode_in = 1'b0; valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      tick();
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      checks++; if (err_count_out !== 16'd0) begin errors++; $display("[TB] FAIL clear_count: got %0h expected 0", err_count_out); end
      checks++; if (sticky_err_out !== 1'b0) begin errors++; $display("[TB] FAIL clear_sticky: got %0h expected 0", sticky_err_out); end
      tick();
      checks++; if (err_count_out !== 16'd0) begin errors++; $display("[TB] FAIL clear_beat_dropped: got %0h expected 0", err_count_out); end
   endtask

   task automatic test_saturation();
      logic [1:0] exp_sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      clear_in = 1'b1;
      tick();
      clear_in = 1'b0;
      data_in = 28'h0004000; parity_in = 4'b0000; odd_mode_in = 1'b0; valid_in = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         tick();
         if (i == 5) valid_in = 1'b0;
         if (i >= 3) begin
            checks++;
            if (count2 !== exp_sat[i-3]) begin errors++; $display("[TB] FAIL sat_count_%0d: got %0d expected %0d", i-2, count2, exp_sat[i-3]); end
         end
      end
      checks++; if (err_count_out !== 16'd5) begin errors++; $display("[TB] FAIL wide_count: got %0d expected 5", err_count_out); end
   endtask

   task automatic test_reset_mid();
      data_in = 28'h0004000; parity_in = 4'b0000; odd_mode_in = 1'b0; valid_in = 1'b1;
      tick();
      tick();
      valid_in = 1'b0;
      #2;
      rst_n_in = 1'b0;
      #1;
      checks++; if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_valid: got %0h expected 0", valid_out); end
      checks++; if (err_count_out !== 16'd0) begin errors++; $display("[TB] FAIL rst_mid_count: got %0h expected 0", err_count_out); end
      checks++; if (sticky_err_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_sticky: got %0h expected 0", sticky_err_out); end
      @(negedge clk_in);
      rst_n_in = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL rst_no_beat_%0d: got %0h expected 0", i, valid_out); end
      end
   endtask

   initial begin
      test_reset();
      test_pass();
      test_lane_error();
      test_back_to_back();
      test_clear();
      test_saturation();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
